// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder
//
// Rate encoder for the LIF neuron. It turns a Q1.15 intensity into a
// Bernoulli spike train that runs for a programmable number of cycles. Each
// bit compares a 16-bit Galois LFSR against the latched intensity. Frames
// enter through a valid/ready handshake. A one-cycle frame_done pulse marks
// the end of each frame, and spike_count gives the number of 1s emitted in
// that frame.
//
// Ports:
//   clk           single clock, rising edge
//   rst           asynchronous, active-high reset
//   in_valid      frame request (must be held until in_ready)
//   in_ready      encoder is IDLE and can accept a frame
//   in_intensity  firing probability, Q1.15 (>= 16'h8000 always fires)
//   in_window     frame length in cycles (0 = empty frame)
//   seed_valid    (RATE_ENC_RESEED_EN only) load seed_value into the LFSR in IDLE
//   seed_value    (RATE_ENC_RESEED_EN only) new LFSR seed, 0 maps to 16'h0001
//   spike_bit     spike train, drives the neuron's in_bit
//   frame_active  high while the frame's bits are emitted
//   frame_done    one-cycle pulse at frame end
//   spike_count   number of 1s in the current or last frame
//
// Optional feature: define RATE_ENC_RESEED_EN to add the runtime reseed
// ports. Without it, only reset sets the LFSR, to LFSR_SEED.

module spike_rate_encoder #(
  parameter int          WIDTH     = 16,
  parameter int          WINDOW_W  = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_intensity,
  input  logic [WINDOW_W-1:0] in_window,
`ifdef RATE_ENC_RESEED_EN
  input  logic                seed_valid,
  input  logic [15:0]         seed_value,
`endif
  output logic                spike_bit,
  output logic                frame_active,
  output logic                frame_done,
  output logic [WINDOW_W-1:0] spike_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // An all-zero Galois LFSR locks up. A zero seed is therefore mapped to 1.
  localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [WIDTH-1:0]    int_q, int_d;
  logic [WINDOW_W-1:0] rem_q, rem_d;
  logic [WINDOW_W-1:0] cnt_q, cnt_d;

  logic [15:0]         lfsr_step;
  logic [WIDTH-1:0]    lfsr_cmp;
  logic                fire;

  // Galois step: shift right, and fold the mask in when a 1 falls out.
  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

  // The comparison uses the top 15 LFSR bits as an unsigned number in
  // [0, 32767]. Intensity 0 therefore never fires, and an intensity of
  // 32768 or more always fires. This assumes WIDTH >= 15.
  assign lfsr_cmp = WIDTH'(lfsr_q[15:1]);
  assign fire     = (lfsr_cmp < int_q);

  // All outputs decode directly from registered state. An asynchronous
  // reset therefore forces them to their idle values immediately.
  assign in_ready     = (state_q == IDLE);
  assign frame_active = (state_q == ACTIVE);
  assign frame_done   = (state_q == DONE);
  assign spike_bit    = (state_q == ACTIVE) && fire;
  assign spike_count  = cnt_q;

  always_comb begin
    // NOTE: every *_d gets a hold default first. A branch that does not
    // assign a signal then keeps the current value, and no latch is inferred.
    state_d = state_q;
    lfsr_d  = lfsr_q;
    int_d   = int_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
`ifdef RATE_ENC_RESEED_EN
        // The new seed lands on the same edge as an accept. The first bit
        // of that frame therefore already uses the new seed.
        if (seed_valid) begin
          lfsr_d = (seed_value == 16'h0000) ? 16'h0001 : seed_value;
        end
`endif
        if (in_valid) begin
          int_d   = in_intensity;
          rem_d   = in_window;
          cnt_d   = '0;
          state_d = (in_window != '0) ? ACTIVE : DONE;
        end
      end

      ACTIVE: begin
        // The LFSR steps only while bits are emitted. The sequence therefore
        // depends only on the seed and the number of bits produced so far.
        lfsr_d = lfsr_step;
        rem_d  = rem_q - 1'b1;
        if (fire) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (rem_q == WINDOW_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops
  // update together on the edge, whatever order the statements are in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_EFF;
      int_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      int_q   <= int_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Self-checking bench for spike_rate_encoder.
// An independent LFSR model precomputes each frame's bits and count into
// scoreboard queues when the frame is requested. The bench pops and compares
// those entries while the DUT emits the frame.
// Define RATE_ENC_RESEED_EN to also exercise the reseed ports.

module tb_spike_rate_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_intensity;
  logic [7:0]  in_window;
  logic        spike_bit;
  logic        frame_active;
  logic        frame_done;
  logic [7:0]  spike_count;
`ifdef RATE_ENC_RESEED_EN
  logic        seed_valid;
  logic [15:0] seed_value;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] m_lfsr;
  logic        exp_bits[$];
  int          exp_cnt[$];
  int          last_cnt;

  spike_rate_encoder #(
    .WIDTH    (16),
    .WINDOW_W (8),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_intensity(in_intensity),
    .in_window   (in_window),
`ifdef RATE_ENC_RESEED_EN
    .seed_valid  (seed_valid),
    .seed_value  (seed_value),
`endif
    .spike_bit   (spike_bit),
    .frame_active(frame_active),
    .frame_done  (frame_done),
    .spike_count (spike_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change, and outputs are sampled, 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_next(input logic [15:0] s);
    logic [15:0] sh;
    sh = {1'b0, s[15:1]};
    if (s[0]) sh = sh ^ 16'hB400;
    return sh;
  endfunction

  // Run one frame from IDLE. 'noise' keeps a bogus request (full intensity)
  // asserted while busy. 'seed_mid' pulses seed_valid during ACTIVE.
  task automatic run_frame(input string tag, input logic [15:0] inten,
                           input logic [7:0] win, input bit noise, input bit seed_mid);
    int cnt;
    logic b;
    cnt = 0;
    check({tag, "_ready"}, in_ready, 1);
    in_valid     = 1'b1;
    in_intensity = inten;
    in_window    = win;
    for (int k = 0; k < win; k++) begin
      b = ({1'b0, m_lfsr[15:1]} < inten);
      exp_bits.push_back(b);
      cnt += int'(b);
      m_lfsr = model_next(m_lfsr);
    end
    exp_cnt.push_back(cnt);
    last_cnt = cnt;
    tick();                                   // accept edge E0
    in_valid = noise;
    if (noise) in_intensity = 16'hFFFF;
`ifdef RATE_ENC_RESEED_EN
    seed_valid = seed_mid;
    seed_value = 16'h1234;
`endif
    for (int k = 0; k < win; k++) begin
      check({tag, "_active"}, frame_active, 1);
      check({tag, "_nodone"}, frame_done, 0);
      if (exp_bits.size() != 0) check({tag, "_bit"}, spike_bit, exp_bits.pop_front());
      else check({tag, "_sb_empty"}, 1, 0);
      tick();
    end
`ifdef RATE_ENC_RESEED_EN
    seed_valid = 1'b0;
`endif
    in_valid = 1'b0;
    check({tag, "_done"}, frame_done, 1);
    check({tag, "_done_inactive"}, frame_active, 0);
    check({tag, "_done_spike0"}, spike_bit, 0);
    if (exp_cnt.size() != 0) check({tag, "_count"}, spike_count, exp_cnt.pop_front());
    else check({tag, "_cnt_empty"}, 1, 0);
    tick();
    check({tag, "_ready_again"}, in_ready, 1);
    check({tag, "_done_pulse"}, frame_done, 0);
    check({tag, "_count_hold"}, spike_count, last_cnt);
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_intensity = '0;
    in_window    = '0;
`ifdef RATE_ENC_RESEED_EN
    seed_valid   = 1'b0;
    seed_value   = '0;
`endif
    m_lfsr = 16'hACE1;
    #3;
    check("rst_ready", in_ready, 1);
    check("rst_spike", spike_bit, 0);
    check("rst_active", frame_active, 0);
    check("rst_done", frame_done, 0);
    check("rst_count", spike_count, 0);
    tick();
    rst = 1'b0;

    // Half probability, full window, starting from the reset seed.
    run_frame("half255", 16'd16384, 8'd255, 1'b0, 1'b0);
    check("half255_range", (last_cnt >= 100 && last_cnt <= 155), 1);

    // Intensity 0 never fires. A request held high while busy is ignored.
    run_frame("zero100", 16'h0000, 8'd100, 1'b1, 1'b0);
    check("zero100_cnt_zero", spike_count, 0);

    // Saturated intensity fires every cycle.
    run_frame("full10", 16'h8000, 8'd10, 1'b0, 1'b0);
    check("full10_cnt_ten", spike_count, 10);

    // Window 0 with the request held: frame_done every other cycle.
    in_valid     = 1'b1;
    in_intensity = 16'hFFFF;
    in_window    = 8'd0;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("w0_done", frame_done, (i % 2 == 0) ? 1 : 0);
      check("w0_active", frame_active, 0);
      check("w0_spike", spike_bit, 0);
      check("w0_count", spike_count, 0);
      if (i == 7) in_valid = 1'b0;
      tick();
    end
    check("w0_idle", in_ready, 1);

    // Asynchronous reset at cycle 5 of a 50-cycle frame.
    in_valid     = 1'b1;
    in_intensity = 16'hFFFF;
    in_window    = 8'd50;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("pre_rst_active", frame_active, 1);
    rst = 1'b1;
    #1;
    check("arst_ready", in_ready, 1);
    check("arst_active", frame_active, 0);
    check("arst_spike", spike_bit, 0);
    check("arst_done", frame_done, 0);
    check("arst_count", spike_count, 0);
    #1;
    rst = 1'b0;
    m_lfsr = 16'hACE1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_nodone", frame_done, 0);
      check("post_rst_ready", in_ready, 1);
    end
    // The sequence after reset must replay from the seed.
    run_frame("replay", 16'd16384, 8'd20, 1'b0, 1'b0);

`ifdef RATE_ENC_RESEED_EN
    // A zero seed in IDLE loads 16'h0001.
    seed_valid = 1'b1;
    seed_value = 16'h0000;
    tick();
    seed_valid = 1'b0;
    m_lfsr = 16'h0001;
    run_frame("seed0", 16'd16384, 8'd16, 1'b0, 1'b0);

    // seed_valid during ACTIVE changes nothing: the next frame continues the
    // model sequence.
    run_frame("seedmid", 16'd16384, 8'd12, 1'b0, 1'b1);
    run_frame("seedmid_after", 16'd16384, 8'd12, 1'b0, 1'b0);

    // Seed and accept on the same edge: the first bit uses the new seed.
    seed_valid = 1'b1;
    seed_value = 16'hBEEF;
    m_lfsr     = 16'hBEEF;
    run_frame("seedacc", 16'd16384, 8'd16, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
